// File: rtl/mode_register_pkg.sv
// Shared definitions for the mode_register family: operation encodings
// used by the register, its next-state step logic and its bus interface.
package mode_register_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_UP   = 3'b010;
  localparam mode_t MODE_DOWN = 3'b011;
  localparam mode_t MODE_SHL  = 3'b100;
  localparam mode_t MODE_SHR  = 3'b101;
  localparam mode_t MODE_ROL  = 3'b110;
  localparam mode_t MODE_CLR  = 3'b111;

endpackage

// File: rtl/mode_register_if.sv
// Operation/status bundle of mode_register: the master issues operations,
// the slave (the register) returns its contents and counter flags.
interface mode_register_if #(
  parameter int WIDTH = 8
);
  import mode_register_pkg::*;

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (output en, output mode, output d, output sin,
                  input q, input tc, input ovf);

  modport slave  (input en, input mode, input d, input sin,
                  output q, output tc, output ovf);

endinterface

// File: rtl/mode_register_step.sv
// Combinational next-value logic of mode_register; wrap_evt flags an UP at the
// top of the range or a DOWN at zero, independent of enable.
module mode_register_step
  import mode_register_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_evt
);

  // One extra bit keeps MODULUS == 2**WIDTH free of special cases.
  localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] d_ext;
  logic [WIDTH:0] q_inc;
  logic [WIDTH:0] q_dec;

  assign q_ext = {1'b0, q};
  assign d_ext = {1'b0, d};
  assign q_inc = q_ext + ONE;
  assign q_dec = q_ext - ONE;

  always_comb begin
    q_next   = q;
    wrap_evt = 1'b0;
    case (mode)
      MODE_LOAD: q_next = (d_ext > TOP) ? TOP[WIDTH-1:0] : d;
      MODE_UP: begin
        if (q_ext >= TOP) begin
          wrap_evt = 1'b1;
          q_next   = (SATURATE != 0) ? TOP[WIDTH-1:0] : '0;
        end else begin
          q_next = q_inc[WIDTH-1:0];
        end
      end
      MODE_DOWN: begin
        // A value left out of range by a shift snaps back to the top quietly.
        if (q_ext == '0) begin
          wrap_evt = 1'b1;
          q_next   = (SATURATE != 0) ? '0 : TOP[WIDTH-1:0];
        end else if (q_ext > TOP) begin
          q_next = TOP[WIDTH-1:0];
        end else begin
          q_next = q_dec[WIDTH-1:0];
        end
      end
      MODE_SHL: q_next = {q[WIDTH-2:0], sin};
      MODE_SHR: q_next = {sin, q[WIDTH-1:1]};
      MODE_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_CLR: q_next = '0;
      default:  q_next = q;
    endcase
  end

endmodule

// File: rtl/mode_register.sv
// Multi-mode WIDTH-bit register: load, modulo count up/down with wrap or
// saturate, shift and rotate, plus terminal-count and sticky overflow flags.
module mode_register
  import mode_register_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0,
  parameter int RST_VAL  = 0
) (
  input  logic           clk,
  input  logic           rst,
  mode_register_if.slave bus
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             ovf_reg;
  logic             wrap_evt;

  mode_register_step #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_step (
    .q        (q_reg),
    .mode     (bus.mode),
    .d        (bus.d),
    .sin      (bus.sin),
    .q_next   (q_next),
    .wrap_evt (wrap_evt)
  );

  // LOAD and CLR clear ovf; they never raise wrap_evt, so no conflict arises.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= WIDTH'(RST_VAL);
      ovf_reg <= 1'b0;
    end else if (bus.en) begin
      q_reg <= q_next;
      if (bus.mode == MODE_LOAD || bus.mode == MODE_CLR) begin
        ovf_reg <= 1'b0;
      end else if (wrap_evt) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign bus.q   = q_reg;
  assign bus.tc  = bus.en & wrap_evt;
  assign bus.ovf = ovf_reg;

endmodule
